// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ        = 3;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int BYTE_W           = 8;

  // Width of an owner index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector. The search begins one slot past
// last_i and wraps, so the previous winner has the lowest priority.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  int   cand;
  logic found;

  // Walk the requesters starting after last_i; the first active one wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(last_i) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = IW'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates several byte streams onto one UART transmitter. A packet
// owner keeps the grant until its last byte is sent or it stays silent
// for LOCK_TIMEOUT cycles.
//
// state  | meaning
// IDLE   | no owner; round-robin accept of the next valid requester
// SEND   | hold full, o_tx_valid high until the transmitter takes it
// LOCKED | mid-packet; only the owner may deliver, idle cycles counted
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*BYTE_W-1:0]   i_req_data,
  input  logic [N_REQ-1:0]          i_req_last,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [BYTE_W-1:0]         o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic [N_REQ-1:0]          o_grant,
  output logic                      o_timeout
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic                hold_full_q, hold_full_d;
  logic [BYTE_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_last_q, hold_last_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_owner_q, last_owner_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                tx_valid_q, tx_valid_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic [N_REQ-1:0]    pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  logic [N_REQ-1:0]    req_ready;
  logic                acc;
  logic [IW-1:0]       sel_idx;
  logic [BYTE_W-1:0]   sel_data;
  logic                sel_last;
  logic                owner_valid;
  logic                tx_xfer;
  logic [CW-1:0]       cnt_inc;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i  (i_req_valid),
    .last_i (last_owner_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Ready is offered only while the hold is empty; in IDLE to the
  // round-robin winner, in LOCKED to the owner alone. Forced low in reset.
  always_comb begin
    req_ready = '0;
    if (i_rst_n && !hold_full_q) begin
      unique case (state_q)
        IDLE:    req_ready = pick_gnt;
        LOCKED:  req_ready = grant_q;
        default: req_ready = '0;
      endcase
    end
  end

  assign acc         = |(i_req_valid & req_ready);
  assign sel_idx     = (state_q == LOCKED) ? owner_q : pick_idx;
  assign sel_data    = i_req_data[int'(sel_idx)*BYTE_W +: BYTE_W];
  assign sel_last    = i_req_last[sel_idx];
  assign owner_valid = i_req_valid[owner_q];
  assign tx_xfer     = tx_valid_q & i_tx_ready;

  // Next-state logic: accept into the hold, drain to the transmitter,
  // and release the lock on last byte or on idle timeout.
  always_comb begin
    state_d      = state_q;
    hold_full_d  = hold_full_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    tx_valid_d   = tx_valid_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    cnt_inc      = (cnt_q == CW'(LOCK_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

    unique case (state_q)
      IDLE, LOCKED: begin
        if (acc) begin
          hold_full_d  = 1'b1;
          hold_data_d  = sel_data;
          hold_last_d  = sel_last;
          tx_valid_d   = 1'b1;
          owner_d      = sel_idx;
          last_owner_d = sel_idx;
          grant_d      = req_ready;
          cnt_d        = '0;
          state_d      = SEND;
        end else if (state_q == LOCKED && !owner_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(LOCK_TIMEOUT)) begin
            timeout_d = 1'b1;
            grant_d   = '0;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
      end
      SEND: begin
        if (tx_xfer) begin
          tx_valid_d  = 1'b0;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          if (hold_last_q) begin
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = LOCKED;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        hold_full_d = 1'b0;
        tx_valid_d  = 1'b0;
        grant_d     = '0;
        cnt_d       = '0;
      end
    endcase
  end

  // State register; reset drops any held byte and lock and hands first
  // priority to requester 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      owner_q      <= '0;
      last_owner_q <= IW'(N_REQ - 1);
      grant_q      <= '0;
      tx_valid_q   <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      tx_valid_q   <= tx_valid_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_req_ready = req_ready;
  assign o_tx_data   = hold_data_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_grant     = grant_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed packets push their expected
// transmit order into a queue, an independent monitor pops on every
// transmitter handshake.
module tb_uart_tx_arb;

  localparam int N  = 3;
  localparam int LT = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic [N-1:0]   grant;
  logic           timeout;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  int cyc           = 0;
  int tx_drop       = 0;
  bit tx_force_low  = 1'b0;
  int busy          = 0;
  int last_xfer_cyc = 0;
  int to_first_cyc  = -1;
  int to_count      = 0;

  uart_tx_arb #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_grant     (grant),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: after each accepted byte it can go busy for tx_drop cycles.
  initial begin : tx_model
    bit x;
    forever begin
      @(negedge clk);
      x = tx_valid && tx_ready && rst_n;
      @(posedge clk);
      #1;
      if (busy > 0) busy--;
      else if (x && tx_drop > 0) busy = tx_drop;
      tx_ready = (busy == 0) && !tx_force_low;
    end
  end

  // Monitor: scoreboard pop on every transmitter handshake, plus protocol checks.
  initial begin : monitor
    bit gap_chk;
    logic [7:0] e;
    gap_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gap_chk = 1'b0;
      end else begin
        chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
        if (gap_chk) chk("tx_gap", int'(tx_valid), 0);
        gap_chk = 1'b0;
        if (timeout) begin
          to_count++;
          if (to_first_cyc < 0) to_first_cyc = cyc;
        end
        if (tx_valid && tx_ready) begin
          gap_chk = 1'b1;
          last_xfer_cyc = cyc;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", int'(tx_data), int'(e));
          end
        end
      end
    end
  end

  // Offer one byte from requester k; check 1-cycle latency and grant once taken.
  task automatic drive(input int k, input logic [7:0] d, input logic l,
                       input int budget, output bit ok);
    logic [N-1:0] g;
    ok = 1'b0;
    req_data[k*8 +: 8] = d;
    req_last[k]        = l;
    req_valid[k]       = 1'b1;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (req_ready[k]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid[k]       = 1'b0;
    req_data[k*8 +: 8] = ~d;
    req_last[k]        = ~l;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req%0d byte %0h not accepted", k, d);
      return;
    end
    @(negedge clk);
    g    = '0;
    g[k] = 1'b1;
    chk("lat_valid", int'(tx_valid), 1);
    chk("lat_data", int'(tx_data), int'(d));
    chk("lat_grant", int'(grant), int'(g));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit o0, o1, o2, o0b;

    // Reset values, with every requester valid to show ready is held low.
    req_valid = '1;
    #2;
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_ready", int'(req_ready), 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single byte with last set.
    exp_q.push_back(8'h55);
    drive(0, 8'h55, 1'b1, 20, o0);
    @(negedge clk);
    chk("single_grant_idle", int'(grant), 0);
    chk("single_tx_idle", int'(tx_valid), 0);
    wait_drain(20);

    // Fairness: req0 beats req2 after reset, then req2 beats a returning req0.
    do_reset();
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hB0);
    fork
      begin
        drive(0, 8'hA0, 1'b1, 20, o0);
        drive(0, 8'hB0, 1'b1, 20, o0b);
      end
      drive(2, 8'hA2, 1'b1, 20, o2);
    join
    wait_drain(50);

    // Lock: req1 packet stays contiguous while req0 waits; slow transmitter.
    to_count = 0;
    tx_drop  = 10;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h30);
    fork
      begin
        drive(1, 8'h41, 1'b0, 50, o1);
        drive(1, 8'h42, 1'b0, 50, o1);
        drive(1, 8'h43, 1'b1, 50, o1);
      end
      drive(0, 8'h30, 1'b1, 300, o0);
    join
    wait_drain(200);
    chk("lock_no_timeout", to_count, 0);
    tx_drop = 0;
    repeat (15) @(posedge clk);
    #1;

    // Timeout: req2 leaves its packet open and goes silent.
    to_count     = 0;
    to_first_cyc = -1;
    exp_q.push_back(8'h77);
    drive(2, 8'h77, 1'b0, 20, o2);
    repeat (15) @(posedge clk);
    #1;
    chk("timeout_pulses", to_count, 1);
    chk("timeout_delay", to_first_cyc - last_xfer_cyc, LT + 1);
    chk("timeout_grant", int'(grant), 0);
    exp_q.push_back(8'h12);
    drive(0, 8'h12, 1'b1, 20, o0);
    chk("req0_after_timeout", int'(o0), 1);
    wait_drain(20);

    // Backpressure then reset mid-SEND; the held byte must never go out.
    @(negedge clk);
    tx_force_low = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    req_data[2*8 +: 8] = 8'hEE;
    req_last[2]        = 1'b1;
    req_valid[2]       = 1'b1;
    drive(1, 8'h99, 1'b1, 20, o1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(tx_valid), 1);
      chk("bp_data", int'(tx_data), 8'h99);
      chk("bp_ready", int'(req_ready), 0);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", int'(tx_valid), 0);
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_ready", int'(req_ready), 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    tx_force_low = 1'b0;

    // Post-reset priority restarts at requester 0, so req1 beats req2.
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    fork
      drive(1, 8'hC1, 1'b1, 20, o1);
      drive(2, 8'hC2, 1'b1, 20, o2);
    join
    wait_drain(50);
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameters SHALL be:
- N_REQ, 3, number of byte-stream requesters (2..8).
- LOCK_TIMEOUT, 4096, idle cycles before a locked owner loses the grant.
REQ-002 Ports SHALL be:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  N_REQ  per-requester byte valid.
- i_req_data  in  N_REQ x 8  per-requester byte.
- i_req_last  in  N_REQ  byte ends requester's packet.
- o_req_ready  out  N_REQ  per-requester accept.
- o_tx_data  out  8  byte to UART transmitter.
- o_tx_valid  out  1  byte valid to transmitter.
- i_tx_ready  in  1  transmitter idle.
- o_grant  out  N_REQ  one-hot current owner, 0 when unowned.
- o_timeout  out  1  one-cycle pulse on lock timeout.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 A requester transfer SHALL occur on a cycle with i_req_valid[k] & o_req_ready[k]; a transmitter transfer SHALL occur on a cycle with o_tx_valid & i_tx_ready.
REQ-005 The FSM SHALL have states IDLE, SEND, LOCKED.
REQ-006 A one-byte holding register SHALL have a full flag.
REQ-007 o_req_ready SHALL be combinational and at most one-hot.
REQ-008 In IDLE with the hold empty, o_req_ready SHALL go to the round-robin winner among valid requesters.
REQ-009 The round-robin search SHALL start at (last_owner+1) mod N_REQ.
REQ-010 In LOCKED with the hold empty, only the owner's o_req_ready SHALL be asserted.
REQ-011 On a requester transfer, the arbiter SHALL:
- latch data and the last flag into the hold;
- set the owner, o_grant and last_owner;
- enter SEND.
REQ-012 SEND SHALL drive o_tx_valid=1 and o_tx_data=hold until a transmitter transfer; o_tx_valid and o_tx_data SHALL be registered.
REQ-013 After a transmitter transfer, o_tx_valid SHALL be 0 for at least one cycle; this covers the one-cycle ready-drop latency of the transmitter.
REQ-014 After the transmitter transfer, the next state SHALL be:
- last flag set: IDLE with o_grant=0;
- otherwise: LOCKED.
REQ-015 In LOCKED, the next owner byte MAY be accepted while the transmitter is busy; SEND then waits for i_tx_ready.
REQ-016 A LOCKED cycle counter SHALL:
- count cycles with the owner valid low;
- clear on an owner transfer;
- saturate, never wrap.
REQ-017 When the counter reaches LOCK_TIMEOUT, the arbiter SHALL:
- pulse o_timeout for 1 cycle;
- enter IDLE with o_grant=0;
- keep last_owner unchanged.
REQ-018 In IDLE with no valid requester, the arbiter SHALL hold state, o_req_ready=0 and o_tx_valid=0.
REQ-019 Bytes of a packet SHALL reach the transmitter in order, without loss or duplication, and never interleaved with another requester's bytes.
REQ-020 A requester's data SHALL be sampled only on its own transfer cycle; changes on non-ready cycles SHALL be ignored.
REQ-021 Latency from a requester transfer to o_tx_valid SHALL be 1 cycle.

Reset
REQ-022 On i_rst_n low, the arbiter SHALL immediately (asynchronously) enter IDLE with:
- hold empty;
- o_tx_valid=0, o_tx_data=0;
- o_req_ready=0, o_grant=0, o_timeout=0;
- counter=0;
- last_owner=N_REQ-1, so requester 0 has first priority.
REQ-023 Reset mid-packet SHALL drop the held byte and the lock; the first post-reset arbitration SHALL follow REQ-022 priority.
REQ-024 Release SHALL be synchronized by the integrating top level; the block SHALL act on the first clock edge after deassertion.

Structure
REQ-025 Package uart_arb_pkg SHALL hold:
- the FSM state enum (IDLE, SEND, LOCKED);
- the default N_REQ and LOCK_TIMEOUT constants;
- the owner-index width function.
REQ-026 Sub-module rr_pick SHALL be a combinational round-robin selector with inputs (request vector, last_owner) and outputs (one-hot grant, index, any).
REQ-027 uart_tx_arb SHALL instantiate one rr_pick and connect directly to the existing 8/N/1 transmitter ready/valid/data ports.

Verification
REQ-028 Single byte: req0 sends 0x55 with last=1, tx ready held 1. Required: o_tx_valid one cycle later with data 0x55; then IDLE with o_grant=0.
REQ-029 Fairness: after reset, req0 and req2 assert valid together. Required: req0 wins. Next contest: req2 wins (last_owner=0 gives order 1,2,0).
REQ-030 Lock: req1 sends 0x41,0x42,0x43 (last on 0x43) while req0 stays valid; tx ready drops 10 cycles per byte. Required: tx sees 41,42,43 contiguous; req0 is then served.
REQ-031 Timeout: with LOCK_TIMEOUT=8, req2 sends one byte with last=0 and then goes silent. Required: o_timeout pulses exactly once, 8 cycles after entering LOCKED; o_grant=0; req0 is then accepted.
REQ-032 Backpressure and reset: hold i_tx_ready=0 with a byte in SEND. Required: o_tx_valid stays 1 with data stable and o_req_ready stays 0. Then pulse i_rst_n low mid-SEND; required: o_tx_valid=0 immediately and the byte is never sent.
